// File: rtl/fetch_pkg.sv
// Shared types and AXI constants for the instruction fetch stage and its buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // AXI size encoding is log2 of the bytes per beat.
    function automatic logic [2:0] axi_size_for(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction buffer: one push port, two read ports (head, head+1), pop of 0/1/2 entries,
// synchronous clear for redirects.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic [1:0]                 pop_cnt,
    output logic [ENTRY_W-1:0]         head0,
    output logic [ENTRY_W-1:0]         head1,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;

    assign rd_ptr_next = rd_ptr + PTR_W'(1);
    assign head0       = mem[rd_ptr];
    assign head1       = mem[rd_ptr_next];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            count  <= count + CNT_W'(push) - CNT_W'(pop_cnt);
        end
    end

    // NOTE: storage is not reset; validity comes only from count, so the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_axi.sv
// AXI4 read-master instruction fetch: one INCR burst at a time into a dual-read FIFO,
// with redirect flush and a fetch_done strobe back to the PC control block.
module inst_fetch_axi
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              redirect,
    output logic              fetch_done,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    output logic              dec_valid0,
    output logic              dec_valid1,
    output logic [31:0]       dec_inst0,
    output logic [31:0]       dec_inst1,
    output logic [ADDR_W-1:0] dec_pc0,
    output logic [ADDR_W-1:0] dec_pc1,
    output logic              dec_err0,
    output logic              dec_err1,
    input  logic              dec_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    logic              redir_seen;
    logic [ADDR_W-1:0] beat_pc;
    logic [ADDR_W-1:0] aligned_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;
    logic              issue_ok;
    logic              beat_fire;
    logic              push;
    logic [1:0]        pop_cnt;
    fetch_entry_t      push_entry;
    fetch_entry_t      head0;
    fetch_entry_t      head1;
    logic              unused_pc_low;

    assign m_arlen   = 8'(BURST_LEN - 1);
    assign m_arsize  = axi_size_for(DATA_W);
    assign m_arburst = AXI_BURST_INCR;

    assign aligned_pc    = {pc_addr[ADDR_W-1:2], 2'b00};
    assign unused_pc_low = &{1'b0, pc_addr[1:0]};

    // Room for a whole burst is reserved before issue, so pushes can never overflow.
    assign free     = CNT_W'(FIFO_DEPTH) - count;
    assign issue_ok = free >= CNT_W'(BURST_LEN);

    assign beat_fire = m_rvalid && m_rready;
    assign push      = (state == DATA) && beat_fire && !redirect;

    assign push_entry.pc   = 32'(beat_pc);
    assign push_entry.inst = 32'(m_rdata);
    assign push_entry.err  = (m_rresp != 2'b00);

    assign dec_valid0 = count >= CNT_W'(1);
    assign dec_valid1 = count >= CNT_W'(2);
    assign pop_cnt    = dec_ready ? {dec_valid1, dec_valid0 & ~dec_valid1} : 2'b00;

    assign dec_inst0 = head0.inst;
    assign dec_inst1 = head1.inst;
    assign dec_pc0   = ADDR_W'(head0.pc);
    assign dec_pc1   = ADDR_W'(head1.pc);
    assign dec_err0  = head0.err;
    assign dec_err1  = head1.err;

    inst_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (push),
        .push_data(push_entry),
        .pop_cnt  (pop_cnt),
        .head0    (head0),
        .head1    (head1),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_rready   <= 1'b0;
            fetch_done <= 1'b0;
            beat_pc    <= '0;
            redir_seen <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!redirect && issue_ok) begin
                        m_araddr   <= aligned_pc;
                        beat_pc    <= aligned_pc;
                        m_arvalid  <= 1'b1;
                        redir_seen <= 1'b0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    // The AR request is never withdrawn; a redirect only turns the burst into a drain.
                    if (redirect) begin
                        redir_seen <= 1'b1;
                    end
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= (redir_seen || redirect) ? DRAIN : DATA;
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        beat_pc <= beat_pc + ADDR_W'(4);
                        if (m_rlast) begin
                            m_rready   <= 1'b0;
                            fetch_done <= !redirect;
                            state      <= IDLE;
                        end else if (redirect) begin
                            state <= DRAIN;
                        end
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat_fire && m_rlast) begin
                        m_rready <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi: the bench acts as AXI slave and decode stage,
// driving at the falling edge and sampling DUT outputs there.
module tb_inst_fetch_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        redirect;
    logic        fetch_done;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        dec_valid0;
    logic        dec_valid1;
    logic [31:0] dec_inst0;
    logic [31:0] dec_inst1;
    logic [31:0] dec_pc0;
    logic [31:0] dec_pc1;
    logic        dec_err0;
    logic        dec_err1;
    logic        dec_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_fetch_axi #(
        .ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .redirect(redirect), .fetch_done(fetch_done),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .dec_valid0(dec_valid0), .dec_valid1(dec_valid1), .dec_inst0(dec_inst0), .dec_inst1(dec_inst1),
        .dec_pc0(dec_pc0), .dec_pc1(dec_pc1), .dec_err0(dec_err0), .dec_err1(dec_err1),
        .dec_ready(dec_ready)
    );

    task automatic idle_inputs();
        redirect  = 1'b0;
        dec_ready = 1'b0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rresp   = 2'b00;
        m_rdata   = '0;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        pc_addr = pc;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ar();
        for (int i = 0; i < 50 && m_arvalid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic ar_handshake();
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
    endtask

    // Sends n beats base+i; beat err_idx returns SLVERR. Updates pc_addr the way PC control would.
    task automatic drive_beats(input logic [31:0] base, input int n, input int err_idx,
                               input logic [31:0] next_pc, output int pulses, output logic first_v);
        pulses  = 0;
        first_v = 1'b0;
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(i);
            m_rlast  = (i == n - 1);
            m_rresp  = (i == err_idx) ? 2'b10 : 2'b00;
            @(negedge clk);
            if (fetch_done === 1'b1) pulses++;
            if (i == 0) first_v = dec_valid0;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        pc_addr  = next_pc;
        repeat (2) begin
            @(negedge clk);
            if (fetch_done === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        pc_addr = 32'h0000_0000;
        repeat (3) @(negedge clk);
        n_checks++; if (m_arvalid !== 1'b0) begin n_errors++; $display("FAIL reset_arvalid: got %b expected 0", m_arvalid); end
        n_checks++; if (m_rready !== 1'b0) begin n_errors++; $display("FAIL reset_rready: got %b expected 0", m_rready); end
        n_checks++; if (fetch_done !== 1'b0) begin n_errors++; $display("FAIL reset_fetch_done: got %b expected 0", fetch_done); end
        n_checks++; if (m_araddr !== 32'h0) begin n_errors++; $display("FAIL reset_araddr: got %h expected 0", m_araddr); end
        n_checks++; if ({dec_valid0, dec_valid1} !== 2'b00) begin n_errors++; $display("FAIL reset_dec_valid: got %b expected 00", {dec_valid0, dec_valid1}); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (m_arvalid !== 1'b1) begin n_errors++; $display("FAIL reset_first_issue: got %b expected 1", m_arvalid); end
    endtask

    task automatic test_basic();
        int   pulses;
        logic first_v;
        do_reset(32'h100);
        wait_ar();
        n_checks++; if (m_arvalid !== 1'b1) begin n_errors++; $display("FAIL basic_ar_timeout: got %b expected 1", m_arvalid); end
        n_checks++; if (m_araddr !== 32'h100) begin n_errors++; $display("FAIL basic_araddr: got %h expected 100", m_araddr); end
        n_checks++; if ({m_arlen, m_arsize, m_arburst} !== {8'd3, 3'b010, 2'b01}) begin n_errors++; $display("FAIL basic_ar_fields: got len %0d size %0d burst %0d expected 3 2 1", m_arlen, m_arsize, m_arburst); end
        ar_handshake();
        n_checks++; if (m_rready !== 1'b1) begin n_errors++; $display("FAIL basic_rready: got %b expected 1", m_rready); end
        drive_beats(32'hA0, 4, -1, 32'h110, pulses, first_v);
        n_checks++; if (first_v !== 1'b1) begin n_errors++; $display("FAIL basic_latency: got %b expected 1", first_v); end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL basic_fetch_done: got %0d pulses expected 1", pulses); end
        n_checks++; if ({dec_valid0, dec_valid1, dec_pc0, dec_pc1, dec_inst0, dec_inst1} !== {2'b11, 32'h100, 32'h104, 32'hA0, 32'hA1}) begin n_errors++; $display("FAIL basic_pair0: got v %b%b pc %h %h inst %h %h expected 11 100 104 a0 a1", dec_valid0, dec_valid1, dec_pc0, dec_pc1, dec_inst0, dec_inst1); end
        dec_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({dec_valid0, dec_valid1, dec_pc0, dec_pc1, dec_inst0, dec_inst1} !== {2'b11, 32'h108, 32'h10C, 32'hA2, 32'hA3}) begin n_errors++; $display("FAIL basic_pair1: got v %b%b pc %h %h inst %h %h expected 11 108 10c a2 a3", dec_valid0, dec_valid1, dec_pc0, dec_pc1, dec_inst0, dec_inst1); end
        @(negedge clk);
        dec_ready = 1'b0;
        n_checks++; if (dec_valid0 !== 1'b0) begin n_errors++; $display("FAIL basic_empty: got %b expected 0", dec_valid0); end
    endtask

    task automatic test_backpressure();
        int   pulses;
        logic first_v;
        do_reset(32'h0);
        wait_ar();
        n_checks++; if (m_araddr !== 32'h0 || m_arvalid !== 1'b1) begin n_errors++; $display("FAIL bp_ar1: got v %b addr %h expected 1 0", m_arvalid, m_araddr); end
        ar_handshake();
        drive_beats(32'h10, 4, -1, 32'h10, pulses, first_v);
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL bp_done1: got %0d expected 1", pulses); end
        wait_ar();
        n_checks++; if (m_araddr !== 32'h10 || m_arvalid !== 1'b1) begin n_errors++; $display("FAIL bp_ar2: got v %b addr %h expected 1 10", m_arvalid, m_araddr); end
        ar_handshake();
        drive_beats(32'h20, 4, -1, 32'h20, pulses, first_v);
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL bp_done2: got %0d expected 1", pulses); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (m_arvalid !== 1'b0) begin n_errors++; $display("FAIL bp_ar_withheld: got %b expected 0 (cycle %0d)", m_arvalid, i); end
            @(negedge clk);
        end
        n_checks++; if ({dec_pc0, dec_pc1, dec_inst0, dec_inst1} !== {32'h0, 32'h4, 32'h10, 32'h11}) begin n_errors++; $display("FAIL bp_head0: got pc %h %h inst %h %h expected 0 4 10 11", dec_pc0, dec_pc1, dec_inst0, dec_inst1); end
        dec_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({dec_pc0, dec_pc1, dec_inst0, dec_inst1} !== {32'h8, 32'hC, 32'h12, 32'h13}) begin n_errors++; $display("FAIL bp_head1: got pc %h %h inst %h %h expected 8 c 12 13", dec_pc0, dec_pc1, dec_inst0, dec_inst1); end
        n_checks++; if (m_arvalid !== 1'b0) begin n_errors++; $display("FAIL bp_ar_after_pop2: got %b expected 0", m_arvalid); end
        @(negedge clk);
        dec_ready = 1'b0;
        n_checks++; if (m_arvalid !== 1'b0) begin n_errors++; $display("FAIL bp_ar_at_pop4: got %b expected 0", m_arvalid); end
        wait_ar();
        n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h20) begin n_errors++; $display("FAIL bp_ar3: got v %b addr %h expected 1 20", m_arvalid, m_araddr); end
        n_checks++; if ({dec_pc0, dec_pc1, dec_inst0, dec_inst1} !== {32'h10, 32'h14, 32'h20, 32'h21}) begin n_errors++; $display("FAIL bp_head2: got pc %h %h inst %h %h expected 10 14 20 21", dec_pc0, dec_pc1, dec_inst0, dec_inst1); end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        n_checks++; if ({dec_valid1, dec_pc0, dec_pc1, dec_inst0, dec_inst1} !== {1'b1, 32'h18, 32'h1C, 32'h22, 32'h23}) begin n_errors++; $display("FAIL bp_head3: got v1 %b pc %h %h inst %h %h expected 1 18 1c 22 23", dec_valid1, dec_pc0, dec_pc1, dec_inst0, dec_inst1); end
    endtask

    task automatic test_redirect_data();
        do_reset(32'h200);
        wait_ar();
        ar_handshake();
        m_rvalid = 1'b1;
        m_rdata  = 32'hB0;
        @(negedge clk);
        m_rdata = 32'hB1;
        @(negedge clk);
        n_checks++; if (dec_valid1 !== 1'b1 || dec_pc1 !== 32'h204) begin n_errors++; $display("FAIL rd_pre: got v1 %b pc1 %h expected 1 204", dec_valid1, dec_pc1); end
        m_rdata  = 32'hB2;
        redirect = 1'b1;
        pc_addr  = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++; if (dec_valid0 !== 1'b0 || fetch_done !== 1'b0) begin n_errors++; $display("FAIL rd_flush: got v0 %b done %b expected 0 0", dec_valid0, fetch_done); end
        m_rdata = 32'hB3;
        m_rlast = 1'b1;
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        n_checks++; if ({dec_valid0, fetch_done, m_rready} !== 3'b000) begin n_errors++; $display("FAIL rd_drained: got v0/done/rready %b expected 000", {dec_valid0, fetch_done, m_rready}); end
        wait_ar();
        n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h40) begin n_errors++; $display("FAIL rd_new_ar: got v %b addr %h expected 1 40", m_arvalid, m_araddr); end
        n_checks++; if (dec_valid0 !== 1'b0) begin n_errors++; $display("FAIL rd_empty: got %b expected 0", dec_valid0); end
    endtask

    task automatic test_redirect_addr();
        int   pulses;
        logic first_v;
        do_reset(32'h80);
        wait_ar();
        n_checks++; if (m_araddr !== 32'h80) begin n_errors++; $display("FAIL ra_araddr: got %h expected 80", m_araddr); end
        redirect = 1'b1;
        pc_addr  = 32'h400;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h80) begin n_errors++; $display("FAIL ra_stable: got v %b addr %h expected 1 80 (cycle %0d)", m_arvalid, m_araddr, i); end
            @(negedge clk);
        end
        ar_handshake();
        drive_beats(32'hC0, 4, -1, 32'h400, pulses, first_v);
        n_checks++; if (pulses != 0 || first_v !== 1'b0) begin n_errors++; $display("FAIL ra_drain: got pulses %0d v0 %b expected 0 0", pulses, first_v); end
        n_checks++; if (dec_valid0 !== 1'b0) begin n_errors++; $display("FAIL ra_empty: got %b expected 0", dec_valid0); end
        wait_ar();
        n_checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h400) begin n_errors++; $display("FAIL ra_new_ar: got v %b addr %h expected 1 400", m_arvalid, m_araddr); end
    endtask

    task automatic test_fault();
        int   pulses;
        logic first_v;
        do_reset(32'h300);
        wait_ar();
        ar_handshake();
        drive_beats(32'hE0, 4, 1, 32'h310, pulses, first_v);
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL fault_done: got %0d expected 1", pulses); end
        n_checks++; if ({dec_pc0, dec_err0, dec_pc1, dec_err1} !== {32'h300, 1'b0, 32'h304, 1'b1}) begin n_errors++; $display("FAIL fault_pair0: got pc %h err %b pc %h err %b expected 300 0 304 1", dec_pc0, dec_err0, dec_pc1, dec_err1); end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        n_checks++; if ({dec_pc0, dec_err0, dec_pc1, dec_err1, dec_inst1} !== {32'h308, 1'b0, 32'h30C, 1'b0, 32'hE3}) begin n_errors++; $display("FAIL fault_pair1: got pc %h err %b pc %h err %b inst %h expected 308 0 30c 0 e3", dec_pc0, dec_err0, dec_pc1, dec_err1, dec_inst1); end
    endtask

    task automatic test_reset_mid();
        do_reset(32'h500);
        wait_ar();
        ar_handshake();
        m_rvalid = 1'b1;
        m_rdata  = 32'hF0;
        @(negedge clk);
        m_rdata = 32'hF1;
        @(negedge clk);
        m_rdata = 32'hF2;
        rst     = 1'b1;
        @(negedge clk);
        n_checks++; if ({m_arvalid, m_rready, dec_valid0, dec_valid1, fetch_done} !== 5'b00000) begin n_errors++; $display("FAIL reset_mid: got arvalid/rready/v0/v1/done %b expected 00000", {m_arvalid, m_rready, dec_valid0, dec_valid1, fetch_done}); end
        m_rvalid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_data();
        test_redirect_addr();
        test_fault();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_axi.md
Name: inst_fetch_axi

Overview:
- AXI4 read-master instruction fetch stage, directly downstream of the PC control block.
- Takes the current fetch PC, issues one INCR burst of BURST_LEN words, and buffers returned instructions with their PCs in a small FIFO.
- Presents up to two instructions per cycle to decode.
- Returns a one-cycle fetch_done pulse on the accepted last beat; the PC control block uses it as its advance strobe (its rlast input).
- A redirect (jal / jalr / conditional jump) flushes buffered and in-flight instructions.

Parameters:
- ADDR_W, 32, address and PC width
- DATA_W, 32, instruction/R-data width; fixed 32, arsize derived from it
- BURST_LEN, 4, beats per burst, power of 2, 2..8
- FIFO_DEPTH, 8, instruction buffer entries, power of 2, >= BURST_LEN

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pc_addr  in  ADDR_W  fetch PC from PC control block
- redirect  in  1  jal OR jalr_jcond from execute; flush request
- fetch_done  out  1  one-cycle pulse on accepted non-discarded last beat; drives PC control rlast
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_araddr  out  ADDR_W  burst start address, bits[1:0] = 0
- m_arlen  out  8  BURST_LEN-1
- m_arsize  out  3  3'b010
- m_arburst  out  2  2'b01 (INCR)
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- m_rdata  in  DATA_W  instruction word
- m_rresp  in  2  response; nonzero = fault
- m_rlast  in  1  last beat
- dec_valid0  out  1  slot 0 valid
- dec_valid1  out  1  slot 1 valid
- dec_inst0, dec_inst1  out  32  instructions, slot 0 older
- dec_pc0, dec_pc1  out  ADDR_W  PCs of slots
- dec_err0, dec_err1  out  1  fetch fault flag per slot
- dec_ready  in  1  decode consumes all valid slots this cycle

Behaviour:
- Reset values: m_arvalid=0, m_rready=0, fetch_done=0, m_araddr=0, FIFO empty, dec_valid0/1=0, state=IDLE. Reset mid-burst abandons the burst; the interconnect is reset together with this block.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE -> ADDR: when no redirect and (free entries - 0) >= BURST_LEN.
  - Latch m_araddr = {pc_addr[ADDR_W-1:2], 2'b00}.
  - Assert m_arvalid next cycle.
  - Beat PC counter loads the same value.
- ADDR:
  - Hold m_arvalid and all AR fields stable until m_arready.
  - On handshake: go to DATA, or to DRAIN if redirect was seen at any point while in ADDR. The AR request is never withdrawn.
- DATA:
  - m_rready=1.
  - Each accepted beat pushes {pc, rdata, rresp!=0} into the FIFO; beat PC += 4.
  - Space was reserved before issue, so a push never overflows.
  - On accepted beat with m_rlast=1: fetch_done=1 for exactly one cycle (registered, the cycle after the beat); go to IDLE.
- DRAIN:
  - m_rready=1; accept and discard beats.
  - On m_rlast, go to IDLE with no fetch_done.
- Redirect:
  - Same cycle: FIFO count cleared to 0 and dec_valid0/1 forced 0 the next cycle.
  - In DATA: beat accepted the same cycle is discarded; go to DRAIN, or to IDLE if that beat is last. fetch_done is suppressed.
  - In IDLE: no issue that cycle; the new pc_addr is sampled on a later cycle.
- Decode output:
  - dec_valid0 = count>=1; dec_valid1 = count>=2; slots read the head and head+1 entries.
  - dec_ready with valid1 pops 2; with only valid0 pops 1.
  - Push and pop in the same cycle are legal: count += pushes - pops.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: AR handshake at cycle N, first beat at N+k -> dec_valid0 at N+k+1.
- Errors: a nonzero rresp marks the entry's err bit. The fetch continues and fetch_done is still generated; decode raises the exception.
- Only one burst is outstanding at a time.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, ADDR, DATA, DRAIN}
  - AXI constants AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010
  - struct fetch_entry_t {pc, inst, err}
- One sub-module: inst_fifo, with 1 push port, 2 read ports, pop-1/pop-2, and a synchronous clear. The FSM and AXI logic stay in the top.

Test Plan:
- Basic fetch: pc_addr=0x100, arready=1, four beats 0xA0..0xA3, dec_ready=1 -> araddr=0x100, arlen=3; decode sees pc 0x100/0x104 and 0x108/0x10C; one fetch_done pulse.
- Backpressure: dec_ready=0 through two bursts from 0x0 -> second burst issues (8 entries fill); third AR is withheld until decode pops >=4; no entry is lost.
- Redirect in DATA after beat 2 of burst at 0x200 -> remaining 2 beats are accepted and dropped; no fetch_done; FIFO empty; next AR uses the new pc_addr=0x40.
- Redirect in ADDR while arready=0 for 3 cycles -> araddr stays stable, all four beats are drained, no decode output and no fetch_done.
- Fault: rresp=2'b10 on beat 1 at 0x300 -> dec_err set only for pc 0x304; fetch_done still pulses.
- Reset mid-burst (rst=1 during beat 2) -> next cycle arvalid=0, rready=0, dec_valid0=0, fetch_done=0.
